// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared I2S constants: default slot length, channel codes and
//            the bit-counter width helper used by the I2S RX and TX blocks.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int WORD_DEF = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  // Bit-counter width for a slot of 'word' sclk cycles; never zero-width.
  function automatic int cnt_width(input int word);
    return (word > 1) ? $clog2(word) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WORD_DEF);

endpackage
`default_nettype wire

// File: rtl/i2s_slot_counter.sv
`default_nettype none
// ============================================================================
// Module   : i2s_slot_counter
// Brief    : Tracks word-select: registered lrclk, edge detect, saturating
//            in-slot bit counter and the lock flag set on the first edge.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_slot_counter
  import i2s_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int CW   = cnt_width(WORD)
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          i_lrclk,
  output logic          o_lrclk_q,
  output logic          o_edge,
  output logic [CW-1:0] o_bit_cnt,
  output logic          o_locked
);

  localparam logic [CW-1:0] c_CNT_MAX = CW'(WORD - 1);

  logic          r_lrclk_q;
  logic          r_locked;
  logic [CW-1:0] r_bit_cnt;
  logic          w_edge;
  logic [CW-1:0] w_cnt_nxt;

  assign w_edge = i_lrclk ^ r_lrclk_q;

  // Counter restarts on every word-select edge and parks at WORD-1 on long slots.
  always_comb begin
    w_cnt_nxt = r_bit_cnt;
    if (w_edge) begin
      w_cnt_nxt = '0;
    end else if (r_bit_cnt != c_CNT_MAX) begin
      w_cnt_nxt = r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrclk_q <= 1'b0;
      r_bit_cnt <= c_CNT_MAX;
      r_locked  <= 1'b0;
    end else begin
      r_lrclk_q <= i_lrclk;
      r_bit_cnt <= w_cnt_nxt;
      if (w_edge) begin
        r_locked <= 1'b1;
      end
    end
  end

  assign o_lrclk_q = r_lrclk_q;
  assign o_edge    = w_edge;
  assign o_bit_cnt = r_bit_cnt;
  assign o_locked  = r_locked;

endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Brief    : Philips I2S slave receiver; delivers left/right samples as a pair.
//            Optional slot-length check enabled by I2S_RX_FRAME_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int BITSIZE = 24,
  parameter int WORD    = WORD_DEF
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid,
  output logic               frame_err
);

  localparam int CW = cnt_width(WORD);

  logic               w_lrclk_q;
  logic               w_edge;
  logic               w_locked;
  logic [CW-1:0]      w_bit_cnt;
  logic [BITSIZE-1:0] w_capt;

  logic [BITSIZE-1:0] r_shreg;
  logic [BITSIZE-1:0] r_left_hold;
  logic               r_have_left;
  logic [BITSIZE-1:0] r_left;
  logic [BITSIZE-1:0] r_right;
  logic               r_valid;

  i2s_slot_counter #(
    .WORD (WORD),
    .CW   (CW)
  ) u_slot_counter (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .i_lrclk   (lrclk),
    .o_lrclk_q (w_lrclk_q),
    .o_edge    (w_edge),
    .o_bit_cnt (w_bit_cnt),
    .o_locked  (w_locked)
  );

  // Word including this cycle's bit, so the edge-cycle LSB lands when BITSIZE==WORD.
  always_comb begin
    w_capt = r_shreg;
    for (int i = 0; i < BITSIZE; i++) begin
      if (int'(w_bit_cnt) == BITSIZE - 1 - i) begin
        w_capt[i] = sdata;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_left_hold <= '0;
      r_have_left <= 1'b0;
      r_left      <= '0;
      r_right     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!w_edge) begin
        r_shreg <= w_capt;
      end else begin
        r_shreg <= '0;
        if (w_locked) begin
          if (w_lrclk_q == CH_LEFT) begin
            r_left_hold <= w_capt;
            r_have_left <= 1'b1;
          end else if (r_have_left) begin
            r_left  <= r_left_hold;
            r_right <= w_capt;
            r_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic [CW-1:0] c_CNT_MAX = CW'(WORD - 1);

  logic r_frame_err;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else if (w_edge && w_locked && (w_bit_cnt != c_CNT_MAX)) begin
      r_frame_err <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  assign left_chan  = r_left;
  assign right_chan = r_right;
  assign valid      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// Bench for i2s_rx: I2S frames at two sample widths checked cycle by cycle
// against a slot-level reference model.
module tb_i2s_rx;

  localparam int WORD = 32;
  localparam int BA   = 24;
  localparam int BB   = 32;
`ifdef I2S_RX_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  logic lrclk = 1'b0;
  logic sdata = 1'b0;

  logic [BA-1:0] la, ra;
  logic          va, fa;
  logic [BB-1:0] lb, rb;
  logic          vb, fb;

  i2s_rx #(.BITSIZE(BA), .WORD(WORD)) u_dut_a (
    .sclk(sclk), .rst_n(rst_n), .lrclk(lrclk), .sdata(sdata),
    .left_chan(la), .right_chan(ra), .valid(va), .frame_err(fa)
  );

  i2s_rx #(.BITSIZE(BB), .WORD(WORD)) u_dut_b (
    .sclk(sclk), .rst_n(rst_n), .lrclk(lrclk), .sdata(sdata),
    .left_chan(lb), .right_chan(rb), .valid(vb), .frame_err(fb)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: bits of the slot in progress and pairing status.
  bit            m_lr      = 1'b0;
  bit            m_locked  = 1'b0;
  bit            m_have    = 1'b0;
  bit            prev_last = 1'b0;
  bit            q[$];
  logic [31:0]   m_hold_a  = '0;
  logic [31:0]   m_hold_b  = '0;
  logic [BA-1:0] e_la = '0, e_ra = '0;
  logic [BB-1:0] e_lb = '0, e_rb = '0;
  bit            e_v   = 1'b0;
  bit            e_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slot bit k goes to sample bit b-1-k; beyond WORD-1 bits keep landing on position WORD-1.
  function automatic logic [31:0] mword(input bit bits[$], input int b);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < bits.size(); k++) begin
      int idx;
      idx = (k < WORD - 1) ? k : WORD - 1;
      if (idx < b) w[b-1-idx] = bits[k];
    end
    return w;
  endfunction

  task automatic model(input bit lr, input bit sd);
    logic [31:0] wa, wb;
    e_v = 1'b0;
    q.push_back(sd);
    if (lr != m_lr) begin
      wa = mword(q, BA);
      wb = mword(q, BB);
      if (!m_locked) begin
        m_locked = 1'b1;
      end else begin
        if (CHK && (q.size() < WORD)) e_err = 1'b1;
        if (!m_lr) begin
          m_hold_a = wa;
          m_hold_b = wb;
          m_have   = 1'b1;
        end else if (m_have) begin
          e_la = m_hold_a[BA-1:0];
          e_ra = wa[BA-1:0];
          e_lb = m_hold_b;
          e_rb = wb;
          e_v  = 1'b1;
        end
      end
      q.delete();
    end
    m_lr = lr;
  endtask

  task automatic check_all();
    chk("valid_a", 32'(va), 32'(e_v));
    chk("left_a", 32'(la), 32'(e_la));
    chk("right_a", 32'(ra), 32'(e_ra));
    chk("ferr_a", 32'(fa), 32'(e_err));
    chk("valid_b", 32'(vb), 32'(e_v));
    chk("left_b", lb, e_lb);
    chk("right_b", rb, e_rb);
    chk("ferr_b", 32'(fb), 32'(e_err));
  endtask

  task automatic step(input bit lr, input bit sd);
    @(negedge sclk);
    lrclk = lr;
    sdata = sd;
    @(posedge sclk);
    if (rst_n) model(lr, sd);
    else e_v = 1'b0;
    #1;
    check_all();
    cyc++;
  endtask

  // One slot of n cycles; slot bit k is on the wire one cycle after lrclk, MSB first.
  task automatic send_slot(input bit ch, input int n, input logic [31:0] w, input int start);
    for (int j = start; j < n; j++) begin
      bit b;
      if (j == 0) b = prev_last;
      else if (j - 1 < WORD) b = w[WORD-j];
      else b = 1'($urandom);
      step(ch, b);
    end
    if (n <= WORD) prev_last = w[WORD-n];
    else prev_last = 1'($urandom);
  endtask

  task automatic reset_async();
    @(negedge sclk);
    #2;
    rst_n = 1'b0;
    #1;
    m_locked = 1'b0; m_have = 1'b0; m_lr = 1'b0; q.delete();
    e_la = '0; e_ra = '0; e_lb = '0; e_rb = '0; e_v = 1'b0; e_err = 1'b0;
    check_all();
  endtask

  initial begin
    int n0, v0, nl, nr;
    // Reset state held for a few cycles, then lock frame.
    repeat (3) step(1'b0, 1'b0);
    rst_n = 1'b1;
    send_slot(1'b0, WORD, $urandom, 0);
    send_slot(1'b1, WORD, $urandom, 0);
    send_slot(1'b0, WORD, {24'hABCDEF, 8'($urandom)}, 0);
    send_slot(1'b1, WORD, {24'h123456, 8'($urandom)}, 0);
    step(1'b0, prev_last);
    chk("abc_valid", 32'(va), 32'd1);
    chk("abc_left", 32'(la), 32'hABCDEF);
    chk("abc_right", 32'(ra), 32'h123456);
    chk("abc_ferr", 32'(fa), 32'd0);

    // Back-to-back pairs.
    send_slot(1'b0, WORD, {24'h000001, 8'($urandom)}, 1);
    send_slot(1'b1, WORD, {24'hFFFFFF, 8'($urandom)}, 0);
    step(1'b0, prev_last);
    n0 = cyc;
    chk("b2b1_left", 32'(la), 32'h000001);
    chk("b2b1_right", 32'(ra), 32'hFFFFFF);
    send_slot(1'b0, WORD, {24'h800000, 8'($urandom)}, 1);
    send_slot(1'b1, WORD, {24'h7FFFFF, 8'($urandom)}, 0);
    step(1'b0, prev_last);
    chk("b2b2_valid", 32'(va), 32'd1);
    chk("b2b2_left", 32'(la), 32'h800000);
    chk("b2b2_right", 32'(ra), 32'h7FFFFF);
    chk("b2b_spacing", 32'(cyc - n0), 32'd64);

    // Full-width sample: LSB arrives on the edge cycle.
    send_slot(1'b0, WORD, 32'hDEADBEEF, 1);
    send_slot(1'b1, WORD, 32'h01234567, 0);
    step(1'b0, prev_last);
    chk("full_left", lb, 32'hDEADBEEF);
    chk("full_right", rb, 32'h01234567);

    // Short left slot of 20 cycles.
    send_slot(1'b0, 20, {24'hABCDEF, 8'($urandom)}, 1);
    send_slot(1'b1, WORD, {24'h123456, 8'($urandom)}, 0);
    step(1'b0, prev_last);
    chk("short_left_a", 32'(la), 32'hABCDE0);
    chk("short_left_b", lb, 32'hABCDE000);
    chk("short_ferr", 32'(fa), 32'(CHK));
    step(1'b0, prev_last);
    chk("short_ferr_sticky", 32'(fa), 32'(CHK));

    // Reset mid right slot, release while lrclk is high.
    send_slot(1'b0, WORD, $urandom, 2);
    send_slot(1'b1, 10, $urandom, 0);
    reset_async();
    repeat (3) step(1'b1, 1'($urandom));
    rst_n = 1'b1;
    send_slot(1'b1, 14, $urandom, 1);
    v0 = 0;
    send_slot(1'b0, WORD, {24'h5A5A5A, 8'($urandom)}, 0);
    send_slot(1'b1, WORD, {24'hC3C3C3, 8'($urandom)}, 0);
    step(1'b0, prev_last);
    chk("relock_valid", 32'(va), 32'd1);
    chk("relock_left", 32'(la), 32'h5A5A5A);
    chk("relock_right", 32'(ra), 32'hC3C3C3);

    // Random frames with occasional odd slot lengths and a reset between pairs.
    for (int f = 0; f < 10; f++) begin
      nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(WORD - 6, WORD + 4)) : WORD;
      nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(WORD - 6, WORD + 4)) : WORD;
      send_slot(1'b0, nl, $urandom, (f == 0) ? 1 : 0);
      send_slot(1'b1, nr, $urandom, 0);
      if (f == 5) begin
        step(1'b0, prev_last);
        reset_async();
        repeat (2) step(1'b0, 1'b0);
        rst_n = 1'b1;
      end
    end
    step(1'b0, prev_last);
    repeat (3) step(1'b0, 1'($urandom));
    v0 = v0 + 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
